// File: rtl/fixed_point_pkg.sv
// Shared fixed-point helpers: width derivation, round-half-up shift and narrowing (saturating or wrapping).
// Used by the dense/residual datapath stages.
package fixed_point_pkg;

    localparam int FXP_MAX_W = 64;
    typedef logic signed [FXP_MAX_W-1:0] fxp_t;

    function automatic int fxp_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of an aligned two-operand sum that can never overflow.
    function automatic int fxp_sum_w(input int din_w, input int din_f, input int bias_w, input int bias_f);
        return fxp_max(din_w, bias_w + (din_f - bias_f)) + 1;
    endfunction

    function automatic int fxp_cnt_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic fxp_t fxp_round_shift(input fxp_t value, input int sh);
        if (sh <= 0)
            return value;
        return (value + (fxp_t'(1) <<< (sh - 1))) >>> sh;
    endfunction

    function automatic fxp_t fxp_narrow_sat(input fxp_t value, input int w);
        fxp_t hi;
        fxp_t lo;
        hi = (fxp_t'(1) <<< (w - 1)) - fxp_t'(1);
        lo = -(fxp_t'(1) <<< (w - 1));
        if (value > hi)
            return hi;
        if (value < lo)
            return lo;
        return value;
    endfunction

    // Keeps the low w bits, re-sign-extended so the caller can truncate safely.
    function automatic fxp_t fxp_narrow_wrap(input fxp_t value, input int w);
        fxp_t t;
        t = value <<< (FXP_MAX_W - w);
        return t >>> (FXP_MAX_W - w);
    endfunction

endpackage

// File: rtl/fixed_bias_add_stream_if.sv
// Stream bundle for the bias-add stage: matmul beat in, bias beat in, biased beat out.
interface fixed_bias_add_stream_if #(
    parameter int DATA_IN_PRECISION_0  = 32,
    parameter int BIAS_PRECISION_0     = 16,
    parameter int DATA_OUT_PRECISION_0 = 16,
    parameter int PARALLELISM_DIM_0    = 1
);
    logic signed [DATA_IN_PRECISION_0-1:0]  data_in  [PARALLELISM_DIM_0];
    logic                                   data_in_valid;
    logic                                   data_in_ready;
    logic signed [BIAS_PRECISION_0-1:0]     bias     [PARALLELISM_DIM_0];
    logic                                   bias_valid;
    logic                                   bias_ready;
    logic signed [DATA_OUT_PRECISION_0-1:0] data_out [PARALLELISM_DIM_0];
    logic                                   data_out_valid;
    logic                                   data_out_ready;
    logic                                   data_out_last;

    modport master (
        output data_in, data_in_valid, bias, bias_valid, data_out_ready,
        input  data_in_ready, bias_ready, data_out, data_out_valid, data_out_last
    );

    modport slave (
        input  data_in, data_in_valid, bias, bias_valid, data_out_ready,
        output data_in_ready, bias_ready, data_out, data_out_valid, data_out_last
    );
endinterface

// File: rtl/fixed_round_narrow.sv
// One lane of the output stage: round-half-up right shift, then narrow to the output width.
// Narrowing saturates when FIXED_BIAS_ADD_SAT_EN is defined, otherwise wraps.
module fixed_round_narrow
    import fixed_point_pkg::*;
#(
    parameter int IN_W  = 33,
    parameter int OUT_W = 16,
    parameter int SH    = 2
) (
    input  logic signed [IN_W-1:0]  i_val,
    output logic signed [OUT_W-1:0] o_val
);
    fxp_t w_wide;
    fxp_t w_rnd;
    fxp_t w_nar;

    always_comb begin
        w_wide = fxp_t'(i_val);
        w_rnd  = fxp_round_shift(w_wide, SH);
`ifdef FIXED_BIAS_ADD_SAT_EN
        w_nar  = fxp_narrow_sat(w_rnd, OUT_W);
`else
        w_nar  = fxp_narrow_wrap(w_rnd, OUT_W);
`endif
        o_val  = OUT_W'(w_nar);
    end
endmodule

// File: rtl/fixed_bias_add_stream.sv
// Adds the streamed dense-layer bias to the matmul output, 2-stage pipeline, full throughput.
// Output saturation is selected by the FIXED_BIAS_ADD_SAT_EN macro (wrap when undefined).
module fixed_bias_add_stream
    import fixed_point_pkg::*;
#(
    parameter int DATA_IN_PRECISION_0  = 32,
    parameter int DATA_IN_PRECISION_1  = 10,
    parameter int BIAS_PRECISION_0     = 16,
    parameter int BIAS_PRECISION_1     = 3,
    parameter int DATA_OUT_PRECISION_0 = 16,
    parameter int DATA_OUT_PRECISION_1 = 8,
    parameter int TENSOR_SIZE_DIM_0    = 32,
    parameter int PARALLELISM_DIM_0    = 1,
    parameter int DEPTH                = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0
) (
    input  logic                     clk,
    input  logic                     rst,
    fixed_bias_add_stream_if.slave   io_stream
);
    localparam int P     = PARALLELISM_DIM_0;
    localparam int SUM_W = fxp_sum_w(DATA_IN_PRECISION_0, DATA_IN_PRECISION_1,
                                     BIAS_PRECISION_0, BIAS_PRECISION_1);
    localparam int BSH   = DATA_IN_PRECISION_1 - BIAS_PRECISION_1;
    localparam int SH    = DATA_IN_PRECISION_1 - DATA_OUT_PRECISION_1;
    localparam int CNT_W = fxp_cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    if (BIAS_PRECISION_1 > DATA_IN_PRECISION_1) begin : g_chk_bias_frac
        $error("BIAS_PRECISION_1 must not exceed DATA_IN_PRECISION_1");
    end
    if (DATA_OUT_PRECISION_1 > DATA_IN_PRECISION_1) begin : g_chk_out_frac
        $error("DATA_OUT_PRECISION_1 must not exceed DATA_IN_PRECISION_1");
    end
    if ((TENSOR_SIZE_DIM_0 % PARALLELISM_DIM_0) != 0) begin : g_chk_par
        $error("PARALLELISM_DIM_0 must divide TENSOR_SIZE_DIM_0");
    end

    logic                            w_s1_ready;
    logic                            w_s2_ready;
    logic                            w_accept;
    logic signed [SUM_W-1:0]         w_sum     [P];
    logic signed [DATA_OUT_PRECISION_0-1:0] w_nar [P];

    logic                            r_vld_p1;
    logic                            r_last_p1;
    logic signed [SUM_W-1:0]         r_sum_p1  [P];
    logic [CNT_W-1:0]                r_cnt;

    logic                            r_vld_p2;
    logic                            r_last_p2;
    logic signed [DATA_OUT_PRECISION_0-1:0] r_dout_p2 [P];

    // Join both operand streams so the bias index can never drift from the matmul beat.
    assign w_s2_ready              = !r_vld_p2 || io_stream.data_out_ready;
    assign w_s1_ready              = !r_vld_p1 || w_s2_ready;
    assign w_accept                = io_stream.data_in_valid && io_stream.bias_valid && w_s1_ready;
    assign io_stream.data_in_ready = io_stream.bias_valid && w_s1_ready;
    assign io_stream.bias_ready    = io_stream.data_in_valid && w_s1_ready;

    always_comb begin
        for (int i = 0; i < P; i++) begin
            w_sum[i] = SUM_W'(io_stream.data_in[i]) + (SUM_W'(io_stream.bias[i]) <<< BSH);
        end
    end

    // Stage 1: aligned sum and row position.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
            r_cnt     <= '0;
            for (int i = 0; i < P; i++) r_sum_p1[i] <= '0;
        end else begin
            if (w_s1_ready) r_vld_p1 <= w_accept;
            if (w_accept) begin
                r_last_p1 <= (r_cnt == CNT_LAST);
                r_cnt     <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
                for (int i = 0; i < P; i++) r_sum_p1[i] <= w_sum[i];
            end
        end
    end

    for (genvar g = 0; g < P; g++) begin : g_lane
        fixed_round_narrow #(
            .IN_W  (SUM_W),
            .OUT_W (DATA_OUT_PRECISION_0),
            .SH    (SH)
        ) u_round_narrow (
            .i_val (r_sum_p1[g]),
            .o_val (w_nar[g])
        );
    end

    // Stage 2: rounded, narrowed output register; held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_last_p2 <= 1'b0;
            for (int i = 0; i < P; i++) r_dout_p2[i] <= '0;
        end else if (w_s2_ready) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_last_p2 <= r_last_p1;
                for (int i = 0; i < P; i++) r_dout_p2[i] <= w_nar[i];
            end
        end
    end

    assign io_stream.data_out_valid = r_vld_p2;
    assign io_stream.data_out_last  = r_last_p2;

    always_comb begin
        for (int i = 0; i < P; i++) io_stream.data_out[i] = r_dout_p2[i];
    end
endmodule

// File: tb/tb_fixed_bias_add_stream.sv
// Directed-vector bench for fixed_bias_add_stream (defaults, P=1, DEPTH=32); honours FIXED_BIAS_ADD_SAT_EN.
module tb_fixed_bias_add_stream;
    localparam int NV = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fixed_bias_add_stream_if #(
        .DATA_IN_PRECISION_0(32), .BIAS_PRECISION_0(16),
        .DATA_OUT_PRECISION_0(16), .PARALLELISM_DIM_0(1)
    ) bif ();

    fixed_bias_add_stream u_dut (
        .clk       (clk),
        .rst       (rst),
        .io_stream (bif.slave)
    );

    logic [31:0] v_din  [NV];
    logic [15:0] v_bias [NV];
    logic [15:0] v_wrap [NV];
    logic [15:0] v_sat  [NV];

    logic [16:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;
    int beat_idx = 0;
    int vptr = 0;
    bit mon_en = 1'b0;
    bit rdy_rand = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [15:0] exp_of(input int i);
`ifdef FIXED_BIAS_ADD_SAT_EN
        return v_sat[i];
`else
        return v_wrap[i];
`endif
    endfunction

    task automatic set_vec(input int i, input int d, input int b, input int w, input int s);
        v_din[i] = 32'(d); v_bias[i] = 16'(b); v_wrap[i] = 16'(w); v_sat[i] = 16'(s);
    endtask

    // Presents n beats (valid asserted with probability vpct%), recording expectations on acceptance.
    task automatic send(input int n, input int vpct, output int cyc);
        int k;
        k = 0;
        cyc = 0;
        while (k < n) begin
            bif.data_in[0]    = v_din[vptr];
            bif.bias[0]       = v_bias[vptr];
            bif.bias_valid    = 1'b1;
            bif.data_in_valid = ($urandom_range(99) < vpct);
            @(negedge clk);
            if (bif.data_in_valid && bif.data_in_ready) begin
                exp_q.push_back({beat_idx == 31, exp_of(vptr)});
                beat_idx = (beat_idx + 1) % 32;
                vptr = (vptr + 1) % NV;
                k++;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc > 20 * n + 100) begin
                check("send_timeout", 32'(k), 32'(n));
                break;
            end
        end
        bif.data_in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        bif.data_in_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_valid", {31'd0, bif.data_out_valid}, 32'd0);
        check("rst_dout", {16'd0, bif.data_out[0]}, 32'd0);
        check("rst_last", {31'd0, bif.data_out_last}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        beat_idx = 0;
    endtask

    initial begin
        bif.data_out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bif.data_out_ready = rdy_rand ? ($urandom_range(1) == 1) : 1'b1;
        end
    end

    // Scoreboard: every cycle the output is valid it must equal the oldest outstanding beat.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (!bif.data_in_valid)
                    check("bias_ready_join", {31'd0, bif.bias_ready}, 32'd0);
                if (bif.data_out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        check("dout", {16'd0, bif.data_out[0]}, {16'd0, exp_q[0][15:0]});
                        check("last", {31'd0, bif.data_out_last}, {31'd0, exp_q[0][16]});
                        if (bif.data_out_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int cyc;
        set_vec(0,  'h00000400, 'h0008, 'h0200, 'h0200);
        set_vec(1,  'hFFFFFC00, 'hFFF8, 'hFE00, 'hFE00);
        set_vec(2,  'h00000002, 'h0000, 'h0001, 'h0001);
        set_vec(3,  'h00000001, 'h0000, 'h0000, 'h0000);
        set_vec(4,  'h7FFFFC00, 'h0000, 'hFF00, 'h7FFF);
        set_vec(5,  'h80000000, 'h0000, 'h0000, 'h8000);
        set_vec(6,  'h00000006, 'h0000, 'h0002, 'h0002);
        set_vec(7,  'hFFFFFFFA, 'h0000, 'hFFFF, 'hFFFF);
        set_vec(8,  'h00000000, 'h7FFF, 'hFFE0, 'h7FFF);
        set_vec(9,  'h00000100, 'h0001, 'h0060, 'h0060);
        set_vec(10, 'h00003000, 'hFFF0, 'h0A00, 'h0A00);
        set_vec(11, 'hFFFF0000, 'h0010, 'hC200, 'hC200);
        set_vec(12, 'h00000003, 'h0000, 'h0001, 'h0001);
        set_vec(13, 'hFFFFFFFE, 'h0000, 'h0000, 'h0000);

        bif.data_in[0] = '0;
        bif.bias[0] = '0;
        bif.data_in_valid = 1'b0;
        bif.bias_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {31'd0, bif.data_out_valid}, 32'd0);
        check("reset_dout", {16'd0, bif.data_out[0]}, 32'd0);
        check("reset_last", {31'd0, bif.data_out_last}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Join: neither operand may be consumed alone.
        bif.data_in[0] = v_din[0];
        bif.bias[0] = v_bias[0];
        bif.data_in_valid = 1'b1;
        bif.bias_valid = 1'b0;
        #1;
        check("join_din_ready", {31'd0, bif.data_in_ready}, 32'd0);
        check("join_bias_ready", {31'd0, bif.bias_ready}, 32'd1);
        bif.data_in_valid = 1'b0;
        bif.bias_valid = 1'b1;
        #1;
        check("join_din_ready2", {31'd0, bif.data_in_ready}, 32'd1);
        check("join_bias_ready2", {31'd0, bif.bias_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("join_no_output", {31'd0, bif.data_out_valid}, 32'd0);

        // Single beat: 1.0 + 1.0 -> 0x0200, two cycles after acceptance.
        send(1, 100, cyc);
        check("lat_cycle1_valid", {31'd0, bif.data_out_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_cycle2_valid", {31'd0, bif.data_out_valid}, 32'd1);
        check("lat_cycle2_dout", {16'd0, bif.data_out[0]}, 32'h0000_0200);
        drain();

        // Rounding and range corners back to back.
        send(13, 100, cyc);
        drain();

        // Row framing with gappy matmul valid: last on beats 31 and 63 only.
        pulse_reset();
        vptr = 0;
        send(64, 50, cyc);
        drain();

        // Random downstream stalls, then full-rate throughput.
        rdy_rand = 1'b1;
        send(40, 100, cyc);
        drain();
        rdy_rand = 1'b0;
        @(posedge clk); #1;
        send(32, 100, cyc);
        check("throughput_cycles", 32'(cyc), 32'd32);
        drain();

        // Reset with both stages full: row index restarts at 0.
        pulse_reset();
        send(10, 100, cyc);
        check("pre_reset_full_p2", {31'd0, bif.data_out_valid}, 32'd1);
        check("pre_reset_full_p1", {31'd0, u_dut.r_vld_p1}, 32'd1);
        pulse_reset();
        send(32, 100, cyc);
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
